intr_arb: RTL and testbench

INTR_ARB -- requirements
Module: intr_arb

---
 rtl/intr_pkg.sv | 17 +
 rtl/intr_prio_enc.sv | 36 +++
 rtl/intr_arb.sv | 144 ++++++++++++++
 tb/tb_intr_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared arbiter FSM state encodings and interrupt trigger-type codes.
package intr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    INTR_PEDGE = 2'd0,
    INTR_NEDGE = 2'd1,
    INTR_HIGH  = 2'd2,
    INTR_LOW   = 2'd3
  } intr_type_e;

endpackage

// File: rtl/intr_prio_enc.sv
// Rotating priority encoder: first set req bit at or after start, wrapping.
// Purely combinational, zero latency; no flow control.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int INTR_NUM = 8,
  parameter int ID_W     = 3
) (
  input  logic [INTR_NUM-1:0] req,
  input  logic [ID_W-1:0]     start,
  output logic                vld,
  output logic [ID_W-1:0]     id
);

  logic [INTR_NUM-1:0] rot;

  function automatic logic [ID_W-1:0] wrap_id(input int s);
    int w;
    w = (s >= INTR_NUM) ? s - INTR_NUM : s;
    return w[ID_W-1:0];
  endfunction

  // Rotate so that bit 0 of rot is req[start]; lowest set bit of rot wins.
  always_comb begin
    rot = INTR_NUM'({req, req} >> start);
    vld = 1'b0;
    id  = '0;
    for (int i = INTR_NUM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        vld = 1'b1;
        id  = wrap_id(i + int'(start));
      end
    end
  end

endmodule

// File: rtl/intr_arb.sv
// Interrupt arbiter IDLE->PEND->SERVICE; irq 1 cycle after req, 2 cycles after complete; all outputs registered.
// Fixed lowest-index priority, or round-robin when INTR_ARB_ROUND_ROBIN_EN is defined; CPU strobes are never stalled.
module intr_arb
  import intr_pkg::*;
#(
  parameter int INTR_NUM = 8,
  parameter int ID_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INTR_NUM-1:0] intr_sig,
  input  logic [INTR_NUM-1:0] intr_en,
  input  logic                claim,
  input  logic                complete,
  input  logic [ID_W-1:0]     complete_id,
  output logic                irq,
  output logic [ID_W-1:0]     irq_id,
  output logic                intr_clr,
  output logic [INTR_NUM-1:0] intr_clr_sel,
  output logic                cpl_err
);

  state_e              state_q, state_d;
  logic                irq_q, irq_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic                intr_clr_q, intr_clr_d;
  logic [INTR_NUM-1:0] intr_clr_sel_q, intr_clr_sel_d;
  logic                cpl_err_q, cpl_err_d;

  logic [INTR_NUM-1:0] req;
  logic [INTR_NUM-1:0] cur_oh;
  logic                cur_req;
  logic                cpl_match;
  logic                win_vld;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     start_ptr;

  assign req = intr_sig & intr_en;

  always_comb begin
    cur_oh = '0;
    for (int i = 0; i < INTR_NUM; i++) begin
      cur_oh[i] = (irq_id_q == ID_W'(i));
    end
  end

  assign cur_req   = |(req & cur_oh);
  assign cpl_match = (int'(complete_id) < INTR_NUM) && (complete_id == irq_id_q);

`ifdef INTR_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == PEND && claim && cur_req) begin
      rr_ptr_d = (int'(irq_id_q) == INTR_NUM - 1) ? '0 : irq_id_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign start_ptr = rr_ptr_q;
`else
  assign start_ptr = '0;
`endif

  intr_prio_enc #(
    .INTR_NUM (INTR_NUM),
    .ID_W     (ID_W)
  ) u_prio_enc (
    .req   (req),
    .start (start_ptr),
    .vld   (win_vld),
    .id    (win_id)
  );

  always_comb begin
    state_d        = state_q;
    irq_d          = irq_q;
    irq_id_d       = irq_id_q;
    intr_clr_d     = 1'b0;
    intr_clr_sel_d = '0;
    cpl_err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = PEND;
          irq_d    = 1'b1;
          irq_id_d = win_id;
        end
      end
      PEND: begin
        // A withdrawn request beats a simultaneous claim: nothing gets cleared.
        if (!cur_req) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end else if (claim) begin
          state_d        = SERVICE;
          irq_d          = 1'b0;
          intr_clr_d     = 1'b1;
          intr_clr_sel_d = cur_oh;
        end
      end
      SERVICE: begin
        if (complete && cpl_match) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase

    if (complete && !(state_q == SERVICE && cpl_match)) cpl_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      irq_q          <= 1'b0;
      irq_id_q       <= '0;
      intr_clr_q     <= 1'b0;
      intr_clr_sel_q <= '0;
      cpl_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      irq_q          <= irq_d;
      irq_id_q       <= irq_id_d;
      intr_clr_q     <= intr_clr_d;
      intr_clr_sel_q <= intr_clr_sel_d;
      cpl_err_q      <= cpl_err_d;
    end
  end

  assign irq          = irq_q;
  assign irq_id       = irq_id_q;
  assign intr_clr     = intr_clr_q;
  assign intr_clr_sel = intr_clr_sel_q;
  assign cpl_err      = cpl_err_q;

endmodule

// File: tb/tb_intr_arb.sv
// Scoreboard bench for intr_arb: stimulus queues expected output events, monitor matches them by cycle.
module tb_intr_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] intr_sig;
  logic [7:0] intr_en;
  logic       claim;
  logic       complete;
  logic [2:0] complete_id;
  logic       irq;
  logic [2:0] irq_id;
  logic       intr_clr;
  logic [7:0] intr_clr_sel;
  logic       cpl_err;

  intr_arb #(
    .INTR_NUM (8),
    .ID_W     (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .intr_sig     (intr_sig),
    .intr_en      (intr_en),
    .claim        (claim),
    .complete     (complete),
    .complete_id  (complete_id),
    .irq          (irq),
    .irq_id       (irq_id),
    .intr_clr     (intr_clr),
    .intr_clr_sel (intr_clr_sel),
    .cpl_err      (cpl_err)
  );

  always #5 clk = ~clk;

  localparam int EV_FALL = 0;
  localparam int EV_RISE = 1;
  localparam int EV_CLR  = 2;
  localparam int EV_ERR  = 3;

  typedef struct packed {
    int          kind;
    logic [15:0] dat;
    int          cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic prev_irq = 1'b0;
  int   ids[4];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_FALL: return "irq_fall";
      EV_RISE: return "irq_rise";
      EV_CLR:  return "intr_clr";
      default: return "cpl_err";
    endcase
  endfunction

  function automatic logic [15:0] clr_dat(input logic [7:0] sel);
    return {7'b0, 1'b1, sel};
  endfunction

  task automatic push_ev(input int k, input logic [15:0] d, input int c);
    ev_t e;
    e.kind = k;
    e.dat  = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input int k, input logic [15:0] d);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s unexpected: got dat=%h at cyc %0d, required none", kname(k), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.dat != d || e.cyc != cyc) begin
        bad++;
        $display("FAIL %s: got %s dat=%h cyc=%0d, required %s dat=%h cyc=%0d",
                 kname(e.kind), kname(k), d, cyc, kname(e.kind), e.dat, e.cyc);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h, required %h", nm, act, want);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, ".irq"},          16'(irq),          16'h0);
    chk({tag, ".irq_id"},       16'(irq_id),       16'h0);
    chk({tag, ".intr_clr"},     16'(intr_clr),     16'h0);
    chk({tag, ".intr_clr_sel"}, 16'(intr_clr_sel), 16'h0);
    chk({tag, ".cpl_err"},      16'(cpl_err),      16'h0);
  endtask

  // Monitor: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL %s missing: required dat=%h at cyc %0d, not observed", kname(exp_q[0].kind), exp_q[0].dat, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (prev_irq && !irq)                     check_ev(EV_FALL, 16'h0);
      if (!prev_irq && irq)                     check_ev(EV_RISE, 16'(irq_id));
      if (intr_clr || intr_clr_sel != 8'h00)    check_ev(EV_CLR, {7'b0, intr_clr, intr_clr_sel});
      if (cpl_err)                              check_ev(EV_ERR, 16'h0);
    end
    prev_irq = irq;
  end

  task automatic nb();
    @(negedge clk);
    #1;
  endtask

  initial begin
`ifdef INTR_ARB_ROUND_ROBIN_EN
    ids = '{0, 4, 0, 4};
`else
    ids = '{0, 0, 0, 0};
`endif
    rst = 1'b1; intr_sig = 8'h00; intr_en = 8'h00;
    claim = 1'b0; complete = 1'b0; complete_id = 3'd0;
    nb(); nb(); nb();
    check_rst("reset");
    rst = 1'b0;

    // Two requests, lowest index wins one cycle later.
    nb(); intr_en = 8'hFF; intr_sig = 8'h24; push_ev(EV_RISE, 16'd2, cyc + 1);
    nb(); nb();
    claim = 1'b1; push_ev(EV_FALL, 16'h0, cyc + 1); push_ev(EV_CLR, clr_dat(8'h04), cyc + 1);
    nb(); claim = 1'b0; intr_sig = 8'h20;

    // Bad completion id, then the good one; id 5 granted two cycles later.
    nb(); complete = 1'b1; complete_id = 3'd3; push_ev(EV_ERR, 16'h0, cyc + 1);
    nb(); complete = 1'b0;
    nb(); complete = 1'b1; complete_id = 3'd2; push_ev(EV_RISE, 16'd5, cyc + 2);
    nb(); complete = 1'b0;
    nb();

    // Higher-priority arrival while pending must not pre-empt id 5.
    nb(); intr_sig = 8'h21;
    nb(); nb();

    // Mask drops id 5 together with a claim: no clear, back to idle, then id 0.
    intr_en = 8'hDF; claim = 1'b1;
    push_ev(EV_FALL, 16'h0, cyc + 1); push_ev(EV_RISE, 16'd0, cyc + 2);
    nb(); claim = 1'b0;
    nb();

    // Completion while pending is an error and does not change state.
    complete = 1'b1; complete_id = 3'd0; push_ev(EV_ERR, 16'h0, cyc + 1);
    nb(); complete = 1'b0;
    claim = 1'b1; push_ev(EV_FALL, 16'h0, cyc + 1); push_ev(EV_CLR, clr_dat(8'h01), cyc + 1);
    nb(); claim = 1'b0; intr_sig = 8'h04; intr_en = 8'hFF;
    nb(); complete = 1'b1; complete_id = 3'd0; push_ev(EV_RISE, 16'd2, cyc + 2);
    nb(); complete = 1'b0;
    nb();
    claim = 1'b1; push_ev(EV_FALL, 16'h0, cyc + 1); push_ev(EV_CLR, clr_dat(8'h04), cyc + 1);
    nb(); claim = 1'b0;

    // Claim in service is ignored; reset in service abandons the grant.
    claim = 1'b1;
    nb(); claim = 1'b0;
    nb(); rst = 1'b1;
    nb(); check_rst("rst_svc"); rst = 1'b0; push_ev(EV_RISE, 16'd2, cyc + 1);
    nb();

    // Two lines stuck high across repeated claim/complete.
    rst = 1'b1; intr_sig = 8'h11;
    nb(); rst = 1'b0; push_ev(EV_RISE, 16'(ids[0]), cyc + 1);
    for (int g = 0; g < 4; g++) begin
      nb();
      claim = 1'b1;
      push_ev(EV_FALL, 16'h0, cyc + 1);
      push_ev(EV_CLR, clr_dat(8'(1 << ids[g])), cyc + 1);
      nb(); claim = 1'b0;
      complete = 1'b1; complete_id = 3'(ids[g]);
      if (g < 3) push_ev(EV_RISE, 16'(ids[g + 1]), cyc + 2);
      else       intr_sig = 8'h00;
      nb(); complete = 1'b0;
    end

    repeat (4) nb();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
